// File: rtl/mux_scan_n_pkg.sv
// Shared types and helpers for the scanning N:1 word multiplexer.
package mux_pkg;

    // Operating state: idle, manual select, or round-robin scan
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAN  = 2'd1,
        SCAN = 2'd2
    } state_t;

    // Widest channel count the helpers can search over
    localparam int MAX_N  = 256;
    localparam int MAX_NW = $clog2(MAX_N);

    // Next set bit strictly after p, wrapping at n; p itself when it is the
    // only set bit, and p when no bit is set at all.
    function automatic int next_set_after(input logic [MAX_N-1:0] m,
                                          input int n,
                                          input int p);
        int k;
        next_set_after = p;
        // Walk from the farthest candidate to the nearest so the nearest wins
        for (int d = n; d >= 1; d--) begin
            k = p + d;
            if (k >= n) k = k - n;
            if (m[k[MAX_NW-1:0]]) next_set_after = k;
        end
    endfunction

    // Lowest set bit among the first n bits; 0 when none is set.
    function automatic int lowest_set(input logic [MAX_N-1:0] m,
                                      input int n);
        lowest_set = 0;
        for (int k = n - 1; k >= 0; k--) begin
            if (m[k[MAX_NW-1:0]]) lowest_set = k;
        end
    endfunction

endpackage

// File: rtl/mux_nx1_comb.sv
// Combinational N:1 word multiplexer; out-of-range selects produce zero.
module mux_nx1_comb #(
    parameter int W  = 8,
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic [N*W-1:0] i,
    input  logic [SW-1:0]  s,
    output logic [W-1:0]   y
);

    // Compare the select against every legal index; nothing matches when s >= N
    always_comb begin
        y = '0;
        for (int k = 0; k < N; k++) begin
            if (s == SW'(k)) y = i[k*W +: W];
        end
    end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N:1 word multiplexer with manual select or masked round-robin scan.
module mux_scan_n
    import mux_pkg::*;
#(
    parameter int W     = 8,
    parameter int N     = 8,
    parameter int SW    = $clog2(N),
    parameter int DWELL = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] i,
    input  logic [SW-1:0]  s,
    input  logic           mode,
    input  logic           en,
    input  logic [N-1:0]   mask,
    output logic [W-1:0]   y,
    output logic [SW-1:0]  y_sel,
    output logic           y_valid,
    output logic           scan_wrap
);

    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_t         state_q, state_d;
    logic [SW-1:0]  ptr_q, ptr_d;
    logic [DCW-1:0] dwell_q, dwell_d;
    logic           pend_q, pend_d;
    logic [W-1:0]   y_d;
    logic [SW-1:0]  y_sel_d;
    logic           y_valid_d;
    logic           wrap_d;

    logic [W-1:0]   man_y;
    logic [W-1:0]   scan_y;
    logic [SW-1:0]  ptr_next;
    logic [SW-1:0]  ptr_lowest;
    logic           s_legal;

    mux_nx1_comb #(.W(W), .N(N), .SW(SW)) u_man_mux (
        .i (i),
        .s (s),
        .y (man_y)
    );

    mux_nx1_comb #(.W(W), .N(N), .SW(SW)) u_scan_mux (
        .i (i),
        .s (ptr_q),
        .y (scan_y)
    );

    assign ptr_next   = SW'(next_set_after(MAX_N'(mask), N, int'(ptr_q)));
    assign ptr_lowest = SW'(lowest_set(MAX_N'(mask), N));
    assign s_legal    = ({1'b0, s} < (SW+1)'(N));

    // State, pointer, dwell counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            dwell_q   <= '0;
            pend_q    <= 1'b0;
            y         <= '0;
            y_sel     <= '0;
            y_valid   <= 1'b0;
            scan_wrap <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            dwell_q   <= dwell_d;
            pend_q    <= pend_d;
            y         <= y_d;
            y_sel     <= y_sel_d;
            y_valid   <= y_valid_d;
            scan_wrap <= wrap_d;
        end
    end

    // Next state from en/mode every cycle, plus the per-state register updates;
    // a wrap found on an advance is held one cycle so it lines up with the
    // first word of the new round
    always_comb begin
        state_d   = IDLE;
        ptr_d     = ptr_q;
        dwell_d   = dwell_q;
        pend_d    = 1'b0;
        y_d       = y;
        y_sel_d   = y_sel;
        y_valid_d = 1'b0;
        wrap_d    = 1'b0;

        if (en) state_d = mode ? SCAN : MAN;

        case (state_d)
            MAN: begin
                y_d       = man_y;
                y_sel_d   = s;
                y_valid_d = s_legal;
            end
            SCAN: begin
                if (state_q != SCAN) begin
                    ptr_d   = ptr_lowest;
                    dwell_d = '0;
                end else begin
                    y_d       = scan_y;
                    y_sel_d   = ptr_q;
                    y_valid_d = mask[ptr_q];
                    wrap_d    = pend_q;
                    if (dwell_q == DCW'(DWELL - 1)) begin
                        dwell_d = '0;
                        if (|mask) begin
                            ptr_d  = ptr_next;
                            pend_d = (ptr_next <= ptr_q);
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
